// File: rtl/drc_frm_downscaler_nxn_if.sv
// Pixel stream bundle: data, last, valid and ready.
// master drives data/last/vld and samples rdy; slave does the reverse.
interface drc_frm_downscaler_nxn_if #(
    parameter int DW = 24
);
    logic [DW-1:0] pxl_data;
    logic          pxl_last;
    logic          pxl_vld;
    logic          pxl_rdy;

    modport master (
        output pxl_data,
        output pxl_last,
        output pxl_vld,
        input  pxl_rdy
    );

    modport slave (
        input  pxl_data,
        input  pxl_last,
        input  pxl_vld,
        output pxl_rdy
    );
endinterface

// File: rtl/drc_frm_downscaler_nxn.sv
// NxN frame downscaler (N = 2^SCALE_LOG2): average, max or decimate reduction
// through a horizontal register and one line accumulator of COL_NUM/N entries.
// Ports: clk, rst_n (async, active low); bwd (slave) input pixel stream;
// fwd (master) downscaled stream; frm_err_o one-cycle frame alignment error.
// Optional macro DRC_DS_ROUND_EN: average rounds to nearest instead of truncating.
module drc_frm_downscaler_nxn #(
    parameter string DOWNSCALE_TYPE = "AVR-POOLING",
    parameter int    SCALE_LOG2     = 1,
    parameter int    CH_NUM         = 3,
    parameter int    CH_W           = 8,
    parameter int    COL_NUM        = 640,
    parameter int    ROW_NUM        = 480
) (
    input  logic                    clk,
    input  logic                    rst_n,
    drc_frm_downscaler_nxn_if.slave  bwd,
    drc_frm_downscaler_nxn_if.master fwd,
    output logic                    frm_err_o
);
    localparam int N  = 1 << SCALE_LOG2;
    localparam int SH = 2 * SCALE_LOG2;
    localparam int AW = CH_W + SH;
    localparam int DW = CH_NUM * CH_W;
    localparam int LN = COL_NUM / N;
    localparam int CW = $clog2(COL_NUM);
    localparam int RW = $clog2(ROW_NUM);
    localparam int LW = (LN > 1) ? $clog2(LN) : 1;
    localparam bit IS_MAX = (DOWNSCALE_TYPE == "MAX-POOLING");
    localparam bit IS_DEC = (DOWNSCALE_TYPE == "DECIMATE");
`ifdef DRC_DS_ROUND_EN
    localparam logic [AW-1:0] RND = AW'(1 << (SH - 1));
`else
    localparam logic [AW-1:0] RND = '0;
`endif

    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic [LW-1:0]        idx;
    logic                 col_first;
    logic                 col_end;
    logic                 row_first;
    logic                 row_end;
    logic                 col_wrap;
    logic                 row_wrap;
    logic                 fin;
    logic                 blk;
    logic                 acc;
    logic                 abort;
    logic                 push;
    logic                 pop;
    logic                 vld;
    logic [1:0]           cnt;
    logic                 wp;
    logic                 rp;
    logic                 err_q;
    logic [DW-1:0]        obuf_data [2];
    logic                 obuf_last [2];
    logic [AW-1:0]        h_q [CH_NUM];
    logic [AW-1:0]        h_d [CH_NUM];
    logic [AW-1:0]        l_d [CH_NUM];
    logic [CH_NUM*AW-1:0] line_mem [LN];
    logic [CH_NUM*AW-1:0] line_rd;
    logic [CH_NUM*AW-1:0] line_wr;
    logic [DW-1:0]        res_pk;

    assign col_first = (col[SCALE_LOG2-1:0] == '0);
    assign col_end   = &col[SCALE_LOG2-1:0];
    assign row_first = (row[SCALE_LOG2-1:0] == '0);
    assign row_end   = &row[SCALE_LOG2-1:0];
    assign col_wrap  = (col == CW'(COL_NUM - 1));
    assign row_wrap  = (row == RW'(ROW_NUM - 1));
    assign fin       = col_wrap & row_wrap;
    assign blk       = col_end & row_end;
    assign idx       = LW'(col >> SCALE_LOG2);

    // Only the block-completing pixel needs a free buffer slot.
    assign bwd.pxl_rdy = ~(blk & (cnt == 2'd2));
    assign acc         = bwd.pxl_vld & bwd.pxl_rdy;
    // A premature last flag drops the partial block.
    assign abort       = bwd.pxl_last & ~fin;
    assign push        = acc & blk & ~abort;
    assign vld         = (cnt != 2'd0);
    assign pop         = vld & fwd.pxl_rdy;

    assign fwd.pxl_vld  = vld;
    assign fwd.pxl_data = vld ? obuf_data[rp] : '0;
    assign fwd.pxl_last = vld & obuf_last[rp];
    assign frm_err_o    = err_q;

    always_comb begin
        logic [AW-1:0] pix;
        logic [AW-1:0] lv;
        line_rd = line_mem[idx];
        line_wr = '0;
        res_pk  = '0;
        for (int ch = 0; ch < CH_NUM; ch++) begin
            pix = AW'(bwd.pxl_data[ch*CH_W +: CH_W]);
            lv  = line_rd[ch*AW +: AW];
            if (IS_DEC) begin
                h_d[ch] = col_first ? pix : h_q[ch];
                l_d[ch] = row_first ? h_d[ch] : lv;
                res_pk[ch*CH_W +: CH_W] = l_d[ch][CH_W-1:0];
            end else if (IS_MAX) begin
                h_d[ch] = (col_first || pix > h_q[ch]) ? pix : h_q[ch];
                l_d[ch] = (row_first || h_d[ch] > lv) ? h_d[ch] : lv;
                res_pk[ch*CH_W +: CH_W] = l_d[ch][CH_W-1:0];
            end else begin
                h_d[ch] = col_first ? pix : h_q[ch] + pix;
                l_d[ch] = row_first ? h_d[ch] : lv + h_d[ch];
                res_pk[ch*CH_W +: CH_W] = CH_W'((l_d[ch] + RND) >> SH);
            end
            line_wr[ch*AW +: AW] = l_d[ch];
        end
    end

    // Line store needs no reset: row%N==0 always overwrites first.
    always_ff @(posedge clk) begin
        if (acc && col_end) begin
            line_mem[idx] <= line_wr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            if (abort) begin
                col <= '0;
                row <= '0;
            end else if (col_wrap) begin
                col <= '0;
                row <= row_wrap ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            wp    <= 1'b0;
            rp    <= 1'b0;
            err_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                obuf_data[i] <= '0;
                obuf_last[i] <= 1'b0;
            end
            for (int ch = 0; ch < CH_NUM; ch++) begin
                h_q[ch] <= '0;
            end
        end else begin
            err_q <= acc & (bwd.pxl_last ^ fin);
            if (acc) begin
                for (int ch = 0; ch < CH_NUM; ch++) begin
                    h_q[ch] <= h_d[ch];
                end
            end
            if (push) begin
                obuf_data[wp] <= res_pk;
                obuf_last[wp] <= fin;
                wp            <= ~wp;
            end
            if (pop) begin
                rp <= ~rp;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule
